// File: rtl/multiplexer_n_to_1_reg.sv
// Registered N-to-1 multiplexer with a two-entry (main + skid) output buffer.
// Selected words leave in strict FIFO order; Flush empties the buffer, reset clears it.
module multiplexer_n_to_1_reg #(
  parameter  int NBits   = 32,
  parameter  int NInputs = 4,
  localparam int SelBits = $clog2(NInputs)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SelBits-1:0]         Selector,
  input  logic [NInputs*NBits-1:0]   MUX_Data,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic                       Flush,
  output logic [NBits-1:0]           MUX_Output,
  output logic [SelBits-1:0]         Out_Selector,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic                       Sel_Error
);

  // Handshake: a word moves on a rising edge only when valid and ready are both 1
  // on that side; ready never depends combinationally on the partner's valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NBits-1:0]     main_data_q, main_data_d;
  logic [SelBits-1:0]   main_sel_q, main_sel_d;
  logic [NBits-1:0]     skid_data_q, skid_data_d;
  logic [SelBits-1:0]   skid_sel_q, skid_sel_d;
  logic                 sel_err_q, sel_err_d;

  logic [NBits-1:0]     in_word;
  logic                 sel_ok;
  logic                 accept;
  logic                 pop;

  // Out-of-range selectors fall through to channel 0 and leave sel_ok low.
  always_comb begin
    in_word = MUX_Data[NBits-1:0];
    sel_ok  = 1'b0;
    for (int i = 0; i < NInputs; i++) begin
      if (Selector == SelBits'(i)) begin
        in_word = MUX_Data[i*NBits +: NBits];
        sel_ok  = 1'b1;
      end
    end
  end

  assign accept = In_Valid && (state_q != TWO);
  assign pop    = (state_q != EMPTY) && Out_Ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    sel_err_d   = sel_err_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      if (accept && !sel_ok) begin
        sel_err_d = 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_word;
            main_sel_d  = Selector;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data_d = in_word;
            main_sel_d  = Selector;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_word;
            skid_sel_d  = Selector;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign In_Ready     = (state_q != TWO) && !reset;
  assign Out_Valid    = (state_q != EMPTY);
  assign MUX_Output   = main_data_q;
  assign Out_Selector = main_sel_q;
  assign Sel_Error    = sel_err_q;

endmodule

// File: tb/tb_multiplexer_n_to_1_reg.sv
// Bench for multiplexer_n_to_1_reg: directed scenarios plus random traffic,
// checked against a bounded-FIFO reference model with an expected queue.
module tb_multiplexer_n_to_1_reg;
  localparam int NB  = 32;
  localparam int NIN = 5;
  localparam int SB  = $clog2(NIN);
  localparam int W   = NB + SB;

  logic              clk = 1'b0;
  logic              reset;
  logic [SB-1:0]     sel;
  logic [NIN*NB-1:0] mux_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [NB-1:0]     mux_output;
  logic [SB-1:0]     out_sel;
  logic              out_valid;
  logic              out_ready;
  logic              sel_error;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multiplexer_n_to_1_reg #(.NBits(NB), .NInputs(NIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .Selector     (sel),
    .MUX_Data     (mux_data),
    .In_Valid     (in_valid),
    .In_Ready     (in_ready),
    .Flush        (flush),
    .MUX_Output   (mux_output),
    .Out_Selector (out_sel),
    .Out_Valid    (out_valid),
    .Out_Ready    (out_ready),
    .Sel_Error    (sel_error)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  bit           exp_sel_err;
  bit           after_reset;
  int           total;
  int           bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // The word a selector should capture: {selector, channel data}, channel 0 if out of range.
  function automatic logic [W-1:0] ref_word(input logic [NIN*NB-1:0] bus, input logic [SB-1:0] s);
    int idx;
    idx = (int'(s) < NIN) ? int'(s) : 0;
    return {s, bus[idx*NB +: NB]};
  endfunction

  // Monitor compares outputs mid-cycle, then the model advances for the coming edge.
  always @(negedge clk) begin
    bit exp_ir;
    bit acc;
    bit pp;
    exp_ir = !reset && (exp_q.size() < 2);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    check("sel_error", {63'd0, sel_error}, {63'd0, exp_sel_err});
    if (exp_q.size() > 0) begin
      check("mux_output", 64'(mux_output), 64'(exp_q[0][NB-1:0]));
      check("out_selector", 64'(out_sel), 64'(exp_q[0][W-1:NB]));
    end
    if (after_reset) begin
      check("reset_mux_output", 64'(mux_output), 64'd0);
      check("reset_out_selector", 64'(out_sel), 64'd0);
    end
    acc = in_valid && exp_ir && !flush;
    pp  = (exp_q.size() > 0) && out_ready && !flush;
    if (reset) begin
      exp_q.delete();
      exp_sel_err = 1'b0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_word(mux_data, sel));
        if (int'(sel) >= NIN) exp_sel_err = 1'b1;
      end
    end
    after_reset = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [SB-1:0] s, input logic ordy,
                     input logic fl, input logic rst);
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_channels();
    for (int i = 0; i < NIN; i++) mux_data[i*NB +: NB] = 32'hA0 + 32'(i);
  endtask

  task automatic random_channels();
    for (int i = 0; i < NIN; i++) mux_data[i*NB +: NB] = $urandom();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    mux_data  = '0;
    fixed_channels();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // single word on channel 2, one-cycle latency
    cyc(1, 2, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // back-pressure: third offer stalls until the buffer drains
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 1, 0, 0);
    cyc(1, 2, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // streaming with changing data every cycle
    for (int i = 0; i < 16; i++) begin
      random_channels();
      cyc(1, SB'(i % 4), 1, 0, 0);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // out-of-range selector: channel 0 data, sticky error
    fixed_channels();
    cyc(1, 7, 1, 0, 0);
    cyc(1, 4, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // full buffer flushed while a new word is offered
    cyc(1, 1, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    cyc(1, 2, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // reset mid-transfer while the consumer is ready
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // flush and reset together
    cyc(1, 2, 0, 0, 0);
    cyc(1, 7, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      random_channels();
      cyc(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
          SB'($urandom_range(0, 7)),
          ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
